// File: rtl/conv_window_3x3_pkg.sv
// Shared definitions for the 3x3 sliding-window generator: default word width,
// FSM state encoding and a constant-evaluable ceiling log2.
package conv_window_3x3_pkg;

    localparam int DATA_WIDTH_DEF = 32;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FILL   = 2'd1,
        ST_STREAM = 2'd2
    } state_t;

    // Never returns less than 1 so a degenerate size still yields a legal vector.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result++;
        end
        return (result < 1) ? 1 : result;
    endfunction

endpackage

// File: rtl/conv_window_3x3_if.sv
// Pixel-stream input and 3x3 window output bundle of the window generator.
// slave is the generator side, master is the stream source / window consumer.
interface conv_window_3x3_if #(
    parameter int DATA_WIDTH = 32
);
    logic [DATA_WIDTH-1:0] pix_in;
    logic                  pix_valid;
    logic                  pix_sof;
    logic [DATA_WIDTH-1:0] win0;
    logic [DATA_WIDTH-1:0] win1;
    logic [DATA_WIDTH-1:0] win2;
    logic [DATA_WIDTH-1:0] win3;
    logic [DATA_WIDTH-1:0] win4;
    logic [DATA_WIDTH-1:0] win5;
    logic [DATA_WIDTH-1:0] win6;
    logic [DATA_WIDTH-1:0] win7;
    logic [DATA_WIDTH-1:0] win8;
    logic                  win_valid;
    logic                  win_last;
    logic                  busy;

    modport master (
        output pix_in, pix_valid, pix_sof,
        input  win0, win1, win2, win3, win4, win5, win6, win7, win8,
        input  win_valid, win_last, busy
    );

    modport slave (
        input  pix_in, pix_valid, pix_sof,
        output win0, win1, win2, win3, win4, win5, win6, win7, win8,
        output win_valid, win_last, busy
    );
endinterface

// File: rtl/conv_window_3x3_line_buffer.sv
// One-row circular line buffer: single port, read-before-write at one address.
// The asynchronous read lets the window column be formed on the accepting edge.
module conv_window_3x3_line_buffer
    import conv_window_3x3_pkg::*;
#(
    parameter  int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter  int DEPTH      = 28,
    localparam int ADDR_W     = clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  i_wr_en,
    input  logic [ADDR_W-1:0]     i_addr,
    input  logic [DATA_WIDTH-1:0] i_wr_data,
    output logic [DATA_WIDTH-1:0] o_rd_data
);

    logic [DATA_WIDTH-1:0] r_mem [0:DEPTH-1];

    assign o_rd_data = r_mem[i_addr];

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_addr] <= i_wr_data;
        end
    end

endmodule

// File: rtl/conv_window_3x3.sv
// 3x3 sliding-window generator: buffers two image rows and emits every complete
// neighbourhood of a raster pixel stream as nine words plus a valid strobe.
module conv_window_3x3
    import conv_window_3x3_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int IMG_WIDTH  = 28,
    parameter int IMG_HEIGHT = 28
) (
    input  logic             clk,
    input  logic             rst,
    conv_window_3x3_if.slave io_win
);

    localparam int COL_W = clog2(IMG_WIDTH);
    localparam int ROW_W = clog2(IMG_HEIGHT);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
    localparam logic [COL_W-1:0] COL_TWO  = COL_W'(2);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);
    localparam logic [ROW_W-1:0] ROW_TWO  = ROW_W'(2);

    state_t                r_state;
    state_t                w_state_next;
    logic [COL_W-1:0]      r_col;
    logic [COL_W-1:0]      w_cur_col;
    logic [COL_W-1:0]      w_col_next;
    logic [ROW_W-1:0]      r_row;
    logic [ROW_W-1:0]      w_cur_row;
    logic [ROW_W-1:0]      w_row_next;
    logic                  w_accept;
    logic                  w_sof;
    logic                  w_at_last;
    logic                  w_emit;
    logic                  w_busy;
    logic                  r_win_valid;
    logic                  r_win_last;
    logic [DATA_WIDTH-1:0] w_lb0_rd;
    logic [DATA_WIDTH-1:0] w_lb1_rd;
    logic [DATA_WIDTH-1:0] w_new_col [0:2];
    logic [DATA_WIDTH-1:0] w_win     [0:8];

    assign w_accept = io_win.pix_valid;
    assign w_sof    = io_win.pix_valid & io_win.pix_sof;

    // A start-of-frame pixel is position (0,0) whatever the counters hold.
    assign w_cur_col = w_sof ? '0 : r_col;
    assign w_cur_row = w_sof ? '0 : r_row;
    assign w_at_last = (w_cur_row == ROW_LAST) && (w_cur_col == COL_LAST);

    always_comb begin
        w_col_next = r_col;
        w_row_next = r_row;
        if (w_accept) begin
            if (w_cur_col == COL_LAST) begin
                w_col_next = '0;
                w_row_next = w_at_last ? '0 : w_cur_row + ROW_W'(1);
            end else begin
                w_col_next = w_cur_col + COL_W'(1);
                w_row_next = w_cur_row;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_col   <= '0;
            r_row   <= '0;
        end else begin
            r_state <= w_state_next;
            r_col   <= w_col_next;
            r_row   <= w_row_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (w_accept) begin
            if (w_at_last) begin
                w_state_next = ST_IDLE;
            end else if (w_row_next >= ROW_TWO) begin
                w_state_next = ST_STREAM;
            end else begin
                w_state_next = ST_FILL;
            end
        end
    end

    // STREAM implies row>=2, so only the column still gates window emission.
    always_comb begin
        w_busy = (r_state != ST_IDLE);
        w_emit = w_accept && !w_sof && (r_state == ST_STREAM) && (r_col >= COL_TWO);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_win_valid <= 1'b0;
            r_win_last  <= 1'b0;
        end else begin
            r_win_valid <= w_emit;
            r_win_last  <= w_emit && w_at_last;
        end
    end

    // lb0 ages row r-1 into row r-2 as lb1 takes the incoming row.
    conv_window_3x3_line_buffer #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (IMG_WIDTH)
    ) u_lb0 (
        .clk       (clk),
        .i_wr_en   (w_accept),
        .i_addr    (w_cur_col),
        .i_wr_data (w_lb1_rd),
        .o_rd_data (w_lb0_rd)
    );

    conv_window_3x3_line_buffer #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (IMG_WIDTH)
    ) u_lb1 (
        .clk       (clk),
        .i_wr_en   (w_accept),
        .i_addr    (w_cur_col),
        .i_wr_data (io_win.pix_in),
        .o_rd_data (w_lb1_rd)
    );

    assign w_new_col[0] = w_lb0_rd;
    assign w_new_col[1] = w_lb1_rd;
    assign w_new_col[2] = io_win.pix_in;

    for (genvar gi = 0; gi < 3; gi++) begin : g_win_row
        logic [DATA_WIDTH-1:0] r_tap [0:2];

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                r_tap <= '{default: '0};
            end else if (w_accept) begin
                r_tap[0] <= r_tap[1];
                r_tap[1] <= r_tap[2];
                r_tap[2] <= w_new_col[gi];
            end
        end

        assign w_win[3*gi]     = r_tap[0];
        assign w_win[3*gi + 1] = r_tap[1];
        assign w_win[3*gi + 2] = r_tap[2];
    end

    assign io_win.win0      = w_win[0];
    assign io_win.win1      = w_win[1];
    assign io_win.win2      = w_win[2];
    assign io_win.win3      = w_win[3];
    assign io_win.win4      = w_win[4];
    assign io_win.win5      = w_win[5];
    assign io_win.win6      = w_win[6];
    assign io_win.win7      = w_win[7];
    assign io_win.win8      = w_win[8];
    assign io_win.win_valid = r_win_valid;
    assign io_win.win_last  = r_win_last;
    assign io_win.busy      = w_busy;

endmodule

// File: tb/tb_conv_window_3x3.sv
// Bench for conv_window_3x3: a 4x4 instance for the directed frame scenarios and
// a default 28x28 instance for a random stream, both checked against an image model.
module tb_conv_window_3x3;

    localparam int DW = 32;

    typedef struct packed {
        logic               valid;
        logic               last;
        logic               busy;
        logic [8:0][DW-1:0] w;
    } out_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    conv_window_3x3_if #(.DATA_WIDTH(DW)) if_s ();
    conv_window_3x3_if #(.DATA_WIDTH(DW)) if_l ();

    conv_window_3x3 #(.DATA_WIDTH(DW), .IMG_WIDTH(4), .IMG_HEIGHT(4)) dut_s (
        .clk    (clk),
        .rst    (rst),
        .io_win (if_s)
    );

    conv_window_3x3 #(.DATA_WIDTH(DW), .IMG_WIDTH(28), .IMG_HEIGHT(28)) dut_l (
        .clk    (clk),
        .rst    (rst),
        .io_win (if_l)
    );

    int          n_tests;
    int          n_fail;
    int          m_dim [2] = '{4, 28};
    logic [DW-1:0] m_img [2][28][28];
    int          m_r   [2];
    int          m_c   [2];
    out_t        m_out [2];

    function automatic out_t sample(input int sel);
        out_t o;
        if (sel == 0) begin
            o.valid = if_s.win_valid; o.last = if_s.win_last; o.busy = if_s.busy;
            o.w[0] = if_s.win0; o.w[1] = if_s.win1; o.w[2] = if_s.win2;
            o.w[3] = if_s.win3; o.w[4] = if_s.win4; o.w[5] = if_s.win5;
            o.w[6] = if_s.win6; o.w[7] = if_s.win7; o.w[8] = if_s.win8;
        end else begin
            o.valid = if_l.win_valid; o.last = if_l.win_last; o.busy = if_l.busy;
            o.w[0] = if_l.win0; o.w[1] = if_l.win1; o.w[2] = if_l.win2;
            o.w[3] = if_l.win3; o.w[4] = if_l.win4; o.w[5] = if_l.win5;
            o.w[6] = if_l.win6; o.w[7] = if_l.win7; o.w[8] = if_l.win8;
        end
        return o;
    endfunction

    task automatic model_reset();
        for (int s = 0; s < 2; s++) begin
            m_r[s]   = 0;
            m_c[s]   = 0;
            m_out[s] = '0;
        end
    endtask

    task automatic drive_idle();
        if_s.pix_valid = 1'b0; if_s.pix_sof = 1'b0; if_s.pix_in = '0;
        if_l.pix_valid = 1'b0; if_l.pix_sof = 1'b0; if_l.pix_in = '0;
    endtask

    // One clock: drive the selected stream, advance the image model, sample after the edge.
    task automatic step(input int sel, input bit v, input bit sof, input logic [DW-1:0] d,
                        output out_t exp, output out_t obs);
        out_t e;
        int   r;
        int   c;
        int   dim;
        drive_idle();
        if (sel == 0) begin
            if_s.pix_valid = v; if_s.pix_sof = sof; if_s.pix_in = d;
        end else begin
            if_l.pix_valid = v; if_l.pix_sof = sof; if_l.pix_in = d;
        end
        @(posedge clk);
        dim     = m_dim[sel];
        e       = m_out[sel];
        e.valid = 1'b0;
        e.last  = 1'b0;
        if (v) begin
            r = sof ? 0 : m_r[sel];
            c = sof ? 0 : m_c[sel];
            m_img[sel][r][c] = d;
            e.busy = 1'b1;
            if (r >= 2 && c >= 2) begin
                e.valid = 1'b1;
                for (int i = 0; i < 3; i++)
                    for (int j = 0; j < 3; j++)
                        e.w[i*3 + j] = m_img[sel][r-2+i][c-2+j];
            end
            if (e.valid && r == dim - 1 && c == dim - 1) begin
                e.last = 1'b1;
                e.busy = 1'b0;
            end
            c++;
            if (c == dim) begin
                c = 0;
                r++;
                if (r == dim) r = 0;
            end
            m_r[sel] = r;
            m_c[sel] = c;
        end
        m_out[sel] = e;
        exp = e;
        @(negedge clk);
        obs = sample(sel);
    endtask

    task automatic test_reset();
        out_t o;
        rst = 1'b0;
        drive_idle();
        @(negedge clk);
        @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            o = sample(s);
            n_tests++;
            if (o !== '0) begin
                n_fail++;
                $display("FAIL reset_state inst%0d: got %h, want all zero", s, o);
            end
        end
        model_reset();
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        out_t e, o;
        int   nwin, nlast;
        int   tl [9] = '{0, 1, 2, 4, 5, 6, 8, 9, 10};
        logic [8:0][DW-1:0] want, first;
        nwin = 0; nlast = 0; first = '0;
        for (int p = 0; p < 16; p++) begin
            step(0, 1'b1, p == 0, DW'(p), e, o);
            n_tests++;
            if (o.valid !== e.valid || o.last !== e.last || o.busy !== e.busy || (e.valid && o.w !== e.w)) begin
                n_fail++;
                $display("FAIL basic pix%0d: got v%b l%b b%b w=%h, want v%b l%b b%b w=%h",
                         p, o.valid, o.last, o.busy, o.w, e.valid, e.last, e.busy, e.w);
            end
            if (o.valid === 1'b1) begin
                if (nwin == 0) first = o.w;
                nwin++;
            end
            if (o.last === 1'b1) nlast++;
        end
        for (int k = 0; k < 9; k++) want[k] = DW'(tl[k]);
        n_tests++;
        if (first !== want) begin
            n_fail++;
            $display("FAIL basic_first_window: got %h, want %h", first, want);
        end
        n_tests++;
        if (nwin != 4 || nlast != 1) begin
            n_fail++;
            $display("FAIL basic_counts: got %0d windows %0d last, want 4 windows 1 last", nwin, nlast);
        end
    endtask

    task automatic test_gaps();
        out_t e, o;
        int   nwin;
        nwin = 0;
        for (int p = 0; p < 16; p++) begin
            for (int g = 0; g < 4; g++) begin
                if (g == 0) step(0, 1'b1, p == 0, DW'(p), e, o);
                else        step(0, 1'b0, 1'b0, DW'($urandom), e, o);
                n_tests++;
                if (o.valid !== e.valid || o.last !== e.last || o.busy !== e.busy || (e.valid && o.w !== e.w)) begin
                    n_fail++;
                    $display("FAIL gaps pix%0d gap%0d: got v%b l%b b%b w=%h, want v%b l%b b%b w=%h",
                             p, g, o.valid, o.last, o.busy, o.w, e.valid, e.last, e.busy, e.w);
                end
                if (o.valid === 1'b1) nwin++;
            end
        end
        n_tests++;
        if (nwin != 4) begin
            n_fail++;
            $display("FAIL gaps_valid_cycles: got %0d, want 4", nwin);
        end
    endtask

    task automatic test_back_to_back();
        out_t e, o;
        int   nwin, nlast;
        int   tl [9] = '{16, 17, 18, 20, 21, 22, 24, 25, 26};
        logic [8:0][DW-1:0] want, fifth;
        nwin = 0; nlast = 0; fifth = '0;
        for (int p = 0; p < 32; p++) begin
            step(0, 1'b1, p == 0, DW'(p), e, o);
            n_tests++;
            if (o.valid !== e.valid || o.last !== e.last || o.busy !== e.busy || (e.valid && o.w !== e.w)) begin
                n_fail++;
                $display("FAIL b2b pix%0d: got v%b l%b b%b w=%h, want v%b l%b b%b w=%h",
                         p, o.valid, o.last, o.busy, o.w, e.valid, e.last, e.busy, e.w);
            end
            if (o.valid === 1'b1) begin
                if (nwin == 4) fifth = o.w;
                nwin++;
            end
            if (o.last === 1'b1) nlast++;
        end
        for (int k = 0; k < 9; k++) want[k] = DW'(tl[k]);
        n_tests++;
        if (fifth !== want) begin
            n_fail++;
            $display("FAIL b2b_frame2_first: got %h, want %h", fifth, want);
        end
        n_tests++;
        if (nwin != 8 || nlast != 2) begin
            n_fail++;
            $display("FAIL b2b_counts: got %0d windows %0d last, want 8 windows 2 last", nwin, nlast);
        end
    endtask

    // Abandon a frame at pixel 9, then at the last-pixel slot; sof must win both times.
    task automatic test_sof_abort();
        out_t e, o;
        int   nwin, nlast;
        int   plen [2] = '{9, 15};
        for (int sc = 0; sc < 2; sc++) begin
            nwin = 0; nlast = 0;
            for (int p = 0; p < plen[sc] + 16; p++) begin
                if (p < plen[sc]) step(0, 1'b1, p == 0, DW'(p), e, o);
                else              step(0, 1'b1, p == plen[sc], DW'(100 + p), e, o);
                n_tests++;
                if (o.valid !== e.valid || o.last !== e.last || o.busy !== e.busy || (e.valid && o.w !== e.w)) begin
                    n_fail++;
                    $display("FAIL sof_abort sc%0d pix%0d: got v%b l%b b%b w=%h, want v%b l%b b%b w=%h",
                             sc, p, o.valid, o.last, o.busy, o.w, e.valid, e.last, e.busy, e.w);
                end
                if (o.valid === 1'b1) nwin++;
                if (o.last === 1'b1) nlast++;
            end
            n_tests++;
            if (nwin != (sc == 0 ? 4 : 7) || nlast != 1) begin
                n_fail++;
                $display("FAIL sof_abort_counts sc%0d: got %0d windows %0d last, want %0d windows 1 last",
                         sc, nwin, nlast, sc == 0 ? 4 : 7);
            end
        end
    endtask

    task automatic test_reset_mid();
        out_t e, o;
        int   nwin, nlast;
        for (int p = 0; p < 13; p++) begin
            step(0, 1'b1, p == 0, DW'(p), e, o);
            n_tests++;
            if (o.valid !== e.valid || o.last !== e.last || o.busy !== e.busy || (e.valid && o.w !== e.w)) begin
                n_fail++;
                $display("FAIL reset_mid pre pix%0d: got v%b l%b b%b w=%h, want v%b l%b b%b w=%h",
                         p, o.valid, o.last, o.busy, o.w, e.valid, e.last, e.busy, e.w);
            end
        end
        drive_idle();
        rst = 1'b0;
        @(negedge clk);
        o = sample(0);
        n_tests++;
        if (o !== '0) begin
            n_fail++;
            $display("FAIL reset_mid_outputs: got %h, want all zero", o);
        end
        model_reset();
        rst = 1'b1;
        @(negedge clk);
        nwin = 0; nlast = 0;
        for (int p = 0; p < 16; p++) begin
            step(0, 1'b1, 1'b0, DW'(50 + p), e, o);
            n_tests++;
            if (o.valid !== e.valid || o.last !== e.last || o.busy !== e.busy || (e.valid && o.w !== e.w)) begin
                n_fail++;
                $display("FAIL reset_mid post pix%0d: got v%b l%b b%b w=%h, want v%b l%b b%b w=%h",
                         p, o.valid, o.last, o.busy, o.w, e.valid, e.last, e.busy, e.w);
            end
            if (o.valid === 1'b1) nwin++;
            if (o.last === 1'b1) nlast++;
        end
        n_tests++;
        if (nwin != 4 || nlast != 1) begin
            n_fail++;
            $display("FAIL reset_mid_counts: got %0d windows %0d last, want 4 windows 1 last", nwin, nlast);
        end
    endtask

    task automatic test_random();
        out_t e, o;
        int   acc, nwin, nlast, last_at, cyc;
        acc = 0; nwin = 0; nlast = 0; last_at = -1; cyc = 0;
        while (acc < 784) begin
            if ($urandom_range(0, 3) == 0) begin
                step(1, 1'b0, 1'b0, DW'($urandom), e, o);
            end else begin
                step(1, 1'b1, acc == 0, DW'($urandom), e, o);
                acc++;
            end
            cyc++;
            n_tests++;
            if (o.valid !== e.valid || o.last !== e.last || o.busy !== e.busy || (e.valid && o.w !== e.w)) begin
                n_fail++;
                $display("FAIL random cyc%0d acc%0d: got v%b l%b b%b w=%h, want v%b l%b b%b w=%h",
                         cyc, acc, o.valid, o.last, o.busy, o.w, e.valid, e.last, e.busy, e.w);
            end
            if (o.valid === 1'b1) nwin++;
            if (o.last === 1'b1) begin
                nlast++;
                last_at = nwin;
            end
        end
        n_tests++;
        if (nwin != 676 || nlast != 1 || last_at != 676) begin
            n_fail++;
            $display("FAIL random_counts: got %0d windows %0d last at %0d, want 676 windows 1 last at 676",
                     nwin, nlast, last_at);
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst     = 1'b0;
        drive_idle();
        model_reset();
        @(negedge clk);
        test_reset();
        test_basic();
        test_gaps();
        test_back_to_back();
        test_sof_abort();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
